axi_lite_wrr_arbiter: RTL
=========================

// Module: axi_lite_wrr_arbiter
// PURPOSE
//   Weighted round-robin arbiter feeding the AXI-Lite crossbar's read or write
//   request port (one instance per direction). Chooses among NUM_REQ masters
//   using per-master credit weights. Offers exactly one winner at a time on a
//   req/sel/ack handshake and holds that offer stable until the crossbar
//   acknowledges it.
// PARAMETERS
//   NUM_REQ   4   number of requesters (>=1)
//   WEIGHT_W  4   width of each per-requester weight/credit field
//   SEL_W     derived: max(1,$clog2(NUM_REQ)); not overridable
// PORTS
//   clk_i        in   1                 clock, rising edge
//   rst_i        in   1                 reset, asynchronous, active-high
//   in_req_i     in   NUM_REQ           request per master (AR/AW valid)
//   weight_i     in   NUM_REQ*WEIGHT_W  weight of master i at [i*WEIGHT_W+:WEIGHT_W]
//   out_req_o    out  1                 offer valid (registered)
//   out_sel_o    out  SEL_W             index of offered master (registered)
//   out_ack_i    in   1                 crossbar accepts current offer
//   busy_o       out  1                 =out_req_o; for debug/status
// BEHAVIOUR
//   - Reset (async assert, sync release): out_req_o=0, out_sel_o=0, state=IDLE,
//     ptr=0, all credits=0. Reset asserted mid-offer drops out_req_o immediately.
//   - Weight: effective weight = weight_i[i], or 1 when weight_i[i]==0.
//   - Credit: credit[i]==0 means "fresh". Available credit = credit[i] if nonzero,
//     else the effective weight. Weight changes apply only at the next fresh load.
//   - Search: first i with in_req_i[i]=1, scanning ptr, ptr+1, ... and wrapping
//     modulo NUM_REQ.
//   - FSM IDLE: on any in_req_i bit, register out_req_o<=1 and out_sel_o<=winner,
//     then go to OFFER. A request at edge n gives out_req_o=1 after edge n+1.
//     out_ack_i is ignored in IDLE.
//   - FSM OFFER: out_req_o and out_sel_o stay stable while out_ack_i=0.
//     No re-arbitration occurs, even if in_req_i changes or drops; the AXI
//     valid-stability rule covers that case.
//   - Ack in OFFER (winner w): nxt = available(w)-1.
//     If nxt==0: credit[w]<=0 and ptr<=(w+1) mod NUM_REQ.
//     Otherwise: credit[w]<=nxt and ptr<=w, so w keeps priority.
//     If w!=old ptr, credit[old ptr]<=0 (the unused burst is forfeited).
//     Then out_req_o<=0 and state goes to IDLE.
//   - Throughput: one bubble cycle after each ack. The earliest next offer is
//     two edges after the ack edge.
//   - NUM_REQ=1: out_sel_o is always 0 and credits are irrelevant, but the
//     handshake still applies.
//   - No combinational path from in_req_i or out_ack_i to any output.
// TESTING
//   1 Reset: rst_i=1 while offering -> out_req_o=0 without a clock edge.
//     Release with in_req_i=0 -> outputs stay 0.
//   2 All weights=1, in_req_i=4'b1111, ack every offer -> out_sel_o sequence
//     0,1,2,3,0,1.
//   3 weights w0=3, w1=1, in_req_i=4'b0011, ack every offer -> sequence
//     0,0,0,1,0,0,0,1.
//   4 Hold: in_req_i=4'b0100, out_ack_i=0 for 10 cycles, in_req_i->4'b0001 at
//     cycle 5 -> out_req_o=1 and out_sel_o=2 throughout. After ack, next offer
//     has out_sel_o=0.
//   5 Forfeit: w0=3, w2=1; grant 0 once, then in_req_i=4'b0100 -> grant 2.
//     Re-raise req0 -> grant 0 three times (fresh credit), the first at ptr=3
//     after wrap.
//   6 weight_i all 0, in_req_i=4'b1010 -> sequence 1,3,1,3 (zero weight acts
//     as 1). Ack pulse while out_req_o=0 -> no state change.

Source files
------------

// File: rtl/axi_lite_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_wrr_arbiter
//   Weighted round-robin arbiter in front of one AXI-Lite crossbar request
//   port (instantiate once for reads and once for writes). Each master owns a
//   credit counter that is loaded from its weight. A winner keeps priority
//   until its credit runs out. Exactly one registered offer is presented at a
//   time, and that offer is held stable until the crossbar acknowledges it.
//
// Ports
//   clk_i      in   1                 clock, rising edge
//   rst_i      in   1                 asynchronous active-high reset
//   in_req_i   in   NUM_REQ           per-master request (AR/AW valid)
//   weight_i   in   NUM_REQ*WEIGHT_W  weight of master i at [i*WEIGHT_W+:WEIGHT_W]
//   out_req_o  out  1                 offer valid (registered)
//   out_sel_o  out  SEL_W             index of offered master (registered)
//   out_ack_i  in   1                 crossbar accepts the current offer
//   busy_o     out  1                 copy of out_req_o for status/debug
// -----------------------------------------------------------------------------
module axi_lite_wrr_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int WEIGHT_W = 4,
    localparam int SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            in_req_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight_i,
    output logic                          out_req_o,
    output logic [SEL_W-1:0]              out_sel_o,
    input  logic                          out_ack_i,
    output logic                          busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req;
    logic                w_req_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [WEIGHT_W-1:0] r_credit     [NUM_REQ];
    logic [WEIGHT_W-1:0] w_credit_nxt [NUM_REQ];
    logic [WEIGHT_W-1:0] w_eff_weight [NUM_REQ];

    logic [SEL_W-1:0]    w_winner;
    logic                w_any;
    int                  w_scan_idx;
    logic [WEIGHT_W-1:0] w_avail;
    logic [WEIGHT_W-1:0] w_credit_dec;

    // A zero weight would starve a master, so it behaves as weight 1.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_weight
        logic [WEIGHT_W-1:0] w_raw;
        assign w_raw           = weight_i[g*WEIGHT_W +: WEIGHT_W];
        assign w_eff_weight[g] = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
    end

    // Rotating priority search: first requester at or after r_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a variable unassigned and infers a latch.
        w_winner   = '0;
        w_any      = 1'b0;
        w_scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = int'(r_ptr) + k;
            if (w_scan_idx >= NUM_REQ) begin
                w_scan_idx = w_scan_idx - NUM_REQ;
            end
            if (!w_any && in_req_i[SEL_W'(w_scan_idx)]) begin
                w_any    = 1'b1;
                w_winner = SEL_W'(w_scan_idx);
            end
        end
    end

    // Next-state / next-output logic. Outputs are registered, so neither
    // in_req_i nor out_ack_i reaches a port combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;

        // A zero credit is "fresh": the winner draws on its current weight.
        w_avail      = (r_credit[r_sel] != '0) ? r_credit[r_sel] : w_eff_weight[r_sel];
        w_credit_dec = w_avail - WEIGHT_W'(1);

        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_req_nxt   = 1'b1;
                    w_sel_nxt   = w_winner;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                // The offer is frozen until ack; request changes are ignored.
                if (out_ack_i) begin
                    if (w_credit_dec == '0) begin
                        w_credit_nxt[r_sel] = '0;
                        w_ptr_nxt = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
                    end else begin
                        w_credit_nxt[r_sel] = w_credit_dec;
                        w_ptr_nxt           = r_sel;
                    end
                    // The pointer holder lost its turn, so its remaining burst
                    // is dropped and it reloads fresh next time.
                    if (r_sel != r_ptr) begin
                        w_credit_nxt[r_ptr] = '0;
                    end
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_sel   <= '0;
            r_ptr   <= '0;
            // NOTE: the credit array is reset because zero carries meaning
            // ("fresh"); leaving it unknown would corrupt the first grants.
            for (int i = 0; i < NUM_REQ; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign out_req_o = r_req;
    assign out_sel_o = r_sel;
    assign busy_o    = r_req;

endmodule
